// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : shared types and constants for the RV32I pipeline control path
// Revision: 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_ID_EX  = 2'd0;
    localparam logic [1:0] FWD_EX_MEM = 2'd1;
    localparam logic [1:0] FWD_MEM_WB = 2'd2;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // x0 is hardwired to zero, so a write to it can never be a producer.
    function automatic logic rd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_unit_if : pipeline-register taps in, stall/forward controls out
// Revision: 1.0
// ---------------------------------------------------------------------------
interface hazard_ctrl_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_is_ecall;
    logic [31:0]      id_a7_val;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             is_halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall, id_a7_val,
               ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        input  pc_write, if_id_write, id_ex_bubble, fwd_a_sel, fwd_b_sel,
               is_halted, stall_cnt, bubble_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall, id_a7_val,
               ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        output pc_write, if_id_write, id_ex_bubble, fwd_a_sel, fwd_b_sel,
               is_halted, stall_cnt, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_unit_forward_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// forward_sel : EX operand bypass select; youngest producer (EX/MEM) wins
// Revision: 1.0
// ---------------------------------------------------------------------------
module forward_sel
    import cpu_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] sel
);
    always_comb begin
        sel = FWD_ID_EX;
        if (rd_hit(mem_reg_write, mem_rd, ex_rs)) begin
            sel = FWD_EX_MEM;
        end else if (rd_hit(wb_reg_write, wb_rd, ex_rs)) begin
            sel = FWD_MEM_WB;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_unit : load-use/ecall stalls, forwarding, halt drain, perf counters
// Revision: 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl_unit
    import cpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32,
    parameter int A7_REG       = 17,
    parameter int HALT_CODE    = 10
) (
    input  logic               clk,
    input  logic               reset,
    hazard_ctrl_unit_if.slave  bus
);
    localparam int               DW          = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]    DRAIN_FIRST = 1;
    localparam logic [DW-1:0]    DRAIN_LAST  = DRAIN_CYCLES[DW-1:0];
    localparam logic [4:0]       A7_IDX      = A7_REG[4:0];
    localparam logic [31:0]      HALT_VAL    = HALT_CODE[31:0];
    localparam logic [CNT_W-1:0] CNT_ONE     = 1;

    hz_state_t        r_state;
    logic [DW-1:0]    r_drain_cnt;
    logic             r_is_halted;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_load_use;
    logic w_ecall_dep;
    logic w_stall;
    logic w_run;
    logic w_accept;

    assign w_load_use  = bus.ex_mem_read &&
                         (rd_hit(bus.id_use_rs1, bus.ex_rd, bus.id_rs1) ||
                          rd_hit(bus.id_use_rs2, bus.ex_rd, bus.id_rs2));

    // WB is not checked: the register file writes through to the ID read port.
    assign w_ecall_dep = bus.id_is_ecall &&
                         (rd_hit(bus.ex_reg_write,  bus.ex_rd,  A7_IDX) ||
                          rd_hit(bus.mem_reg_write, bus.mem_rd, A7_IDX));

    assign w_stall  = w_load_use || w_ecall_dep;
    assign w_run    = (r_state == RUN);
    assign w_accept = w_run && bus.id_is_ecall && !w_stall && (bus.id_a7_val == HALT_VAL);

    assign bus.pc_write     = w_run && !w_stall;
    assign bus.if_id_write  = w_run && !w_stall;
    assign bus.id_ex_bubble = !w_run || w_stall;
    assign bus.is_halted    = r_is_halted;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.bubble_cnt   = r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_drain_cnt  <= '0;
            r_is_halted  <= 1'b0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_stall) begin
                        r_stall_cnt  <= r_stall_cnt + CNT_ONE;
                        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
                    end
                    // The halting ecall enters ID/EX as a NOP on this same edge.
                    if (w_accept) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= DRAIN_FIRST;
                    end
                end
                DRAIN: begin
                    r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state     <= HALTED;
                        r_is_halted <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRAIN_FIRST;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    forward_sel u_fwd_a (
        .ex_rs         (bus.ex_rs1),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .sel           (bus.fwd_a_sel)
    );

    forward_sel u_fwd_b (
        .ex_rs         (bus.ex_rs2),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_reg_write),
        .wb_rd         (bus.wb_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .sel           (bus.fwd_b_sel)
    );
endmodule
`default_nettype wire

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Detects load-use and ecall-operand hazards and generates the stall, bubble and forwarding selects for the pipeline registers and ALU operand muxes.
- Runs the halt state machine: drains older instructions after a halting ecall and raises is_halted.
- Keeps stall and bubble performance counters.

Parameters:
- DRAIN_CYCLES, 3, posedges from halt acceptance until is_halted rises. This is the ID/EX to MEM/WB travel of the halt token.
- CNT_W, 32, width of the performance counters.
- A7_REG, 17, register index read by ecall.
- HALT_CODE, 10, a7 value that requests halt.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- id_rs1  in  5  rs1 field of IF/ID instruction; already muxed to A7_REG when id_is_ecall
- id_rs2  in  5  rs2 field of IF/ID instruction
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_is_ecall  in  1  ID instruction is ecall
- id_a7_val  in  32  register-file read of A7_REG
- ex_rs1, ex_rs2  in  5 each  source fields held in ID/EX
- ex_rd  in  5  ID/EX rd
- ex_reg_write  in  1  ID/EX reg_write
- ex_mem_read  in  1  ID/EX mem_read
- mem_rd  in  5  EX/MEM rd
- mem_reg_write  in  1  EX/MEM reg_write
- wb_rd  in  5  MEM/WB rd
- wb_reg_write  in  1  MEM/WB reg_write
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- id_ex_bubble  out  1  load zeros into ID/EX control fields
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 0 = ID/EX data, 1 = EX/MEM alu_out, 2 = MEM/WB write data
- is_halted  out  1  sticky halt indication
- stall_cnt  out  CNT_W  cycles in which load_use or ecall_dep was true
- bubble_cnt  out  CNT_W  cycles with id_ex_bubble=1

Behaviour:
- States: RUN, DRAIN, HALTED. Reset sets state RUN, drain counter 0, is_halted 0, both counters 0.
- Reset has priority over every other event, including reset asserted mid-DRAIN or in HALTED.
- Writes to register 0 never create a hazard and never forward. Every rd match below also requires rd != 0.
- load_use (combinational):
  - true when ex_mem_read and ex_rd matches id_rs1 (with id_use_rs1) or id_rs2 (with id_use_rs2);
  - costs exactly 1 stall cycle.
- ecall_dep (combinational):
  - true when id_is_ecall and either ex_reg_write with ex_rd==A7_REG, or mem_reg_write with mem_rd==A7_REG;
  - there is no forwarding into ID, so the stall lasts up to 2 cycles.
  - WB writing A7_REG does not stall, because the register file is write-through.
- stall = load_use or ecall_dep.
- Outputs in RUN:
  - pc_write = if_id_write = not stall;
  - id_ex_bubble = stall.
- Halt acceptance: in RUN, when id_is_ecall, not stall and id_a7_val==HALT_CODE.
  - The ecall itself passes into ID/EX as a NOP, and this posedge moves the state to DRAIN with drain counter 1.
  - An ecall with any other a7 value is a NOP and the core continues.
- DRAIN:
  - pc_write=0, if_id_write=0, id_ex_bubble=1; the frozen ecall is never re-accepted.
  - The drain counter increments each posedge; when it equals DRAIN_CYCLES the state becomes HALTED.
- HALTED: same enables as DRAIN; is_halted=1 until reset.
- is_halted is registered. With DRAIN_CYCLES=3 it rises exactly 3 posedges after the accepting edge.
- Forwarding (combinational, identical for A using ex_rs1 and B using ex_rs2):
  - select 1 if mem_reg_write and mem_rd matches;
  - otherwise select 2 if wb_reg_write and wb_rd matches;
  - otherwise select 0.
  - EX/MEM has priority when both stages match.
- Counters:
  - increment by 1 on posedge when their condition holds; stall_cnt counts in RUN only;
  - wrap modulo 2^CNT_W;
  - frozen in HALTED.
- When load_use and ecall_dep are both true, the cycle counts once in stall_cnt.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum (RUN, DRAIN, HALTED);
  - forwarding select constants FWD_ID_EX=0, FWD_EX_MEM=1, FWD_MEM_WB=2;
  - opcode defines shared with the control unit.
- One sub-module, forward_sel: purely combinational, instantiated twice (operands A and B).
- The FSM, hazard logic and counters stay in the top module.

Test Plan:
- Load-use stall:
  - Stimulus: lw x5 in EX (ex_mem_read=1, ex_rd=5), ID add reads rs1=5.
  - Expected: one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; then RUN outputs resume; stall_cnt=1, bubble_cnt=1.
- Ecall dependency:
  - Stimulus: addi x17 in EX, ecall in ID.
  - Expected: stall 2 cycles (EX match, then MEM match), release when the addi reaches WB; stall_cnt=2.
- Halt:
  - Stimulus: ecall in ID with id_a7_val=10, no hazard.
  - Expected: accepting edge T; is_halted=0 at T+1 and T+2, 1 after T+3; pc_write stays 0 from T onward; is_halted holds for 20 further cycles.
- Non-halt ecall:
  - Stimulus: id_a7_val=9.
  - Expected: no stall, state stays RUN, is_halted=0.
- Forwarding priority:
  - Stimulus: ex_rs1=7, mem_rd=7, wb_rd=7, both reg_writes=1.
  - Expected: fwd_a_sel=1.
  - Stimulus: mem_reg_write=0.
  - Expected: fwd_a_sel=2.
  - Stimulus: rd=0 with all writes enabled.
  - Expected: fwd_a_sel=0.
- Reset mid-drain:
  - Stimulus: assert reset 1 cycle after halt acceptance.
  - Expected: next edge shows state RUN, is_halted=0, counters 0, pc_write=1.
